// File: rtl/oem_write_scheduler.sv
// Packs the STI serial stream into bytes and writes them, checkerboard-mapped, into the eight
// DAC pixel banks; pads the frame out to 256 pixels after the stream ends.
module oem_write_scheduler #(
  parameter logic [7:0] PAD_VALUE   = 8'h00,
  parameter bit         CHECKER_INV = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       so_data,
  input  logic       so_valid,
  input  logic       pi_end,
  output logic [4:0] oem_addr,
  output logic [7:0] oem_dataout,
  output logic       odd1_wr,
  output logic       odd2_wr,
  output logic       odd3_wr,
  output logic       odd4_wr,
  output logic       even1_wr,
  output logic       even2_wr,
  output logic       even3_wr,
  output logic       even4_wr,
  output logic       oem_finish,
  output logic [8:0] pix_cnt
);

  typedef enum logic [2:0] {
    StCollect, StSetup, StStrobe, StPadSetup, StPadStrobe, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  sr_q, hold_q;
  logic [2:0]  bit_cnt_q;
  logic        pending_q, end_q, prev_valid_q;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  wr_q, wr_d;
  logic [8:0]  pix_q, pix_d, pix_nxt;
  logic        finish_q, finish_d;
  logic        take_byte, accepting, byte_done, arm;

  // Strobe vector layout: bits 0..3 odd1..odd4, bits 4..7 even1..even4.
  function automatic logic [7:0] wr_sel(input logic [1:0] bank, input logic par);
    logic [2:0] idx;
    idx = {par ^ CHECKER_INV, bank};
    return 8'b1 << idx;
  endfunction

  assign accepting = (state_q != StDone);
  assign byte_done = so_valid && accepting && (bit_cnt_q == 3'd7);
  assign arm       = prev_valid_q && !so_valid && pi_end && !end_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q         <= '0;
      hold_q       <= '0;
      bit_cnt_q    <= '0;
      pending_q    <= 1'b0;
      end_q        <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_valid_q <= so_valid;
      if (arm) end_q <= 1'b1;
      if (take_byte) pending_q <= 1'b0;
      if (so_valid && accepting) begin
        sr_q      <= {sr_q[6:0], so_data};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        hold_q    <= {sr_q[6:0], so_data};
        pending_q <= 1'b1;
      end else if (arm && bit_cnt_q != 3'd0) begin
        // Left-justify the partial byte; vacated LSBs are zero.
        hold_q    <= sr_q << (4'd8 - {1'b0, bit_cnt_q});
        pending_q <= 1'b1;
        bit_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = '0;
    pix_d     = pix_q;
    pix_nxt   = pix_q + 9'd1;
    finish_d  = finish_q;
    take_byte = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (pending_q) begin
          take_byte = 1'b1;
          addr_d    = pix_q[5:1];
          data_d    = hold_q;
          state_d   = StSetup;
        end else if (end_q) begin
          addr_d  = pix_q[5:1];
          data_d  = PAD_VALUE;
          state_d = StPadSetup;
        end
      end
      StSetup: begin
        wr_d    = wr_sel(pix_q[7:6], pix_q[4] ^ pix_q[0]);
        state_d = StStrobe;
      end
      StStrobe: begin
        pix_d = pix_nxt;
        if (pix_nxt[8]) begin
          state_d  = StDone;
          finish_d = 1'b1;
        end else begin
          state_d = StCollect;
        end
      end
      StPadSetup: begin
        wr_d    = wr_sel(pix_q[7:6], pix_q[4] ^ pix_q[0]);
        state_d = StPadStrobe;
      end
      StPadStrobe: begin
        pix_d = pix_nxt;
        if (pix_nxt[8]) begin
          state_d  = StDone;
          finish_d = 1'b1;
        end else begin
          addr_d  = pix_nxt[5:1];
          state_d = StPadSetup;
        end
      end
      StDone: ;
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StCollect;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= '0;
      pix_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      pix_q    <= pix_d;
      finish_q <= finish_d;
    end
  end

  assign oem_addr    = addr_q;
  assign oem_dataout = data_q;
  assign odd1_wr     = wr_q[0];
  assign odd2_wr     = wr_q[1];
  assign odd3_wr     = wr_q[2];
  assign odd4_wr     = wr_q[3];
  assign even1_wr    = wr_q[4];
  assign even2_wr    = wr_q[5];
  assign even3_wr    = wr_q[6];
  assign even4_wr    = wr_q[7];
  assign oem_finish  = finish_q;
  assign pix_cnt     = pix_q;

endmodule

// File: tb/tb_oem_write_scheduler.sv
// Scoreboard bench: two schedulers (normal and inverted checkerboard) share one stimulus stream;
// each strobe is popped against a queue of expected writes.
module tb_oem_write_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       so_data = 1'b0;
  logic       so_valid = 1'b0;
  logic       pi_end = 1'b0;
  logic [4:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic [7:0] wr0, wr1;
  logic       fin0, fin1;
  logic [8:0] pix0, pix1;

  always #5 clk = ~clk;

  oem_write_scheduler #(.PAD_VALUE(8'h00), .CHECKER_INV(1'b0)) dut0 (
    .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid), .pi_end(pi_end),
    .oem_addr(addr0), .oem_dataout(data0),
    .odd1_wr(wr0[0]), .odd2_wr(wr0[1]), .odd3_wr(wr0[2]), .odd4_wr(wr0[3]),
    .even1_wr(wr0[4]), .even2_wr(wr0[5]), .even3_wr(wr0[6]), .even4_wr(wr0[7]),
    .oem_finish(fin0), .pix_cnt(pix0)
  );

  oem_write_scheduler #(.PAD_VALUE(8'h00), .CHECKER_INV(1'b1)) dut1 (
    .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid), .pi_end(pi_end),
    .oem_addr(addr1), .oem_dataout(data1),
    .odd1_wr(wr1[0]), .odd2_wr(wr1[1]), .odd3_wr(wr1[2]), .odd4_wr(wr1[3]),
    .even1_wr(wr1[4]), .even2_wr(wr1[5]), .even3_wr(wr1[6]), .even4_wr(wr1[7]),
    .oem_finish(fin1), .pix_cnt(pix1)
  );

  typedef struct packed {
    logic [7:0] wr;
    logic [4:0] addr;
    logic [7:0] data;
    logic [8:0] pix;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  logic prev_any[2] = '{1'b0, 1'b0};
  logic last_flag[2] = '{1'b0, 1'b0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference mapping written from the pixel-index arithmetic.
  task automatic push_exp(input int p, input logic [7:0] d);
    exp_t e;
    int bank, par;
    for (int inv = 0; inv < 2; inv++) begin
      bank   = p / 64;
      par    = ((p / 16) % 2) ^ (p % 2) ^ inv;
      e.wr   = 8'(1 << (bank + 4 * par));
      e.addr = 5'((p % 64) / 2);
      e.data = d;
      e.pix  = 9'(p);
      if (inv == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic mon(input int id, input logic [7:0] wr, input logic [4:0] addr,
                     input logic [7:0] data, input logic [8:0] pix, input logic fin);
    exp_t e;
    int   qs;
    if (last_flag[id]) begin
      check_eq("finish_after_last", 32'(fin), 32'd1);
      check_eq("pix_cnt_256", 32'(pix), 32'd256);
      last_flag[id] = 1'b0;
    end
    if (|wr) begin
      check_eq("wr_back_to_back", 32'(prev_any[id]), 32'd0);
      check_eq("wr_onehot", 32'($countones(wr)), 32'd1);
      qs = (id == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        check_eq("unexpected_wr", 32'(wr), 32'd0);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        check_eq($sformatf("wr%0d_bank", id), 32'(wr), 32'(e.wr));
        check_eq($sformatf("wr%0d_addr", id), 32'(addr), 32'(e.addr));
        check_eq($sformatf("wr%0d_data", id), 32'(data), 32'(e.data));
        check_eq($sformatf("wr%0d_pix", id), 32'(pix), 32'(e.pix));
        check_eq("finish_early", 32'(fin), 32'd0);
        if (e.pix == 9'd255) last_flag[id] = 1'b1;
      end
    end
    prev_any[id] = |wr;
  endtask

  always @(negedge clk) begin
    mon(0, wr0, addr0, data0, pix0, fin0);
    mon(1, wr1, addr1, data1, pix1, fin1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; so_valid = 1'b0; so_data = 1'b0; pi_end = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_addr"}, 32'({addr0, addr1}), 32'd0);
    check_eq({tag, "_data"}, 32'({data0, data1}), 32'd0);
    check_eq({tag, "_wr"}, 32'({wr0, wr1}), 32'd0);
    check_eq({tag, "_pix"}, 32'({pix0, pix1}), 32'd0);
    check_eq({tag, "_fin"}, 32'({fin0, fin1}), 32'd0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      so_valid = 1'b1;
      so_data  = b[7-i];
    end
  endtask

  // Falling so_valid with pi_end high arms end; later pi_end wiggles must be ignored.
  task automatic end_stream();
    @(negedge clk);
    so_valid = 1'b0; so_data = 1'b0; pi_end = 1'b1;
    repeat (4) begin
      @(negedge clk);
      pi_end = ~pi_end;
    end
    pi_end = 1'b0;
  endtask

  task automatic push_pads(input int from);
    for (int p = from; p < 256; p++) push_exp(p, 8'h00);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(fin0 && fin1) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_timeout"}, 32'(n < 4000), 32'd1);
    repeat (5) @(negedge clk);
    check_eq({tag, "_q0_empty"}, 32'(q0.size()), 32'd0);
    check_eq({tag, "_q1_empty"}, 32'(q1.size()), 32'd0);
    check_eq({tag, "_fin_sticky"}, 32'({fin0, fin1}), 32'b11);
    check_eq({tag, "_pix0"}, 32'(pix0), 32'd256);
    check_eq({tag, "_pix1"}, 32'(pix1), 32'd256);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle("reset");

    // Single byte then end: A5 at pixel 0, padding to 255.
    send_bits(8'hA5, 8);
    push_exp(0, 8'hA5);
    push_pads(1);
    end_stream();
    wait_done("single");

    // Full 256-byte stream, value = index; no padding expected.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_bits(8'(i), 8);
      push_exp(i, 8'(i));
    end
    end_stream();
    wait_done("full");

    // Overlong stream: only the first 256 bytes may be written.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      send_bits(8'(i) ^ 8'h5A, 8);
      if (i < 256) push_exp(i, 8'(i) ^ 8'h5A);
    end
    @(negedge clk);
    so_valid = 1'b0;
    wait_done("overlong");

    // Reset during the SETUP cycle: no strobe may follow.
    do_reset();
    send_bits(8'h77, 8);
    @(negedge clk);
    so_valid = 1'b0;
    @(negedge clk);
    check_eq("setup_data", 32'(data0), 32'h77);
    check_eq("setup_nowr", 32'(wr0), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_idle("midreset_after");

    // Partial byte of three ones is zero-filled to E0.
    send_bits(8'hE0, 3);
    push_exp(0, 8'hE0);
    push_pads(1);
    end_stream();
    wait_done("partial");

    // pi_end high with no preceding burst must not arm; then 3C exercises the inverted bank map.
    do_reset();
    pi_end = 1'b1;
    repeat (20) @(negedge clk);
    check_idle("noarm");
    pi_end = 1'b0;
    send_bits(8'h3C, 8);
    push_exp(0, 8'h3C);
    push_pads(1);
    end_stream();
    wait_done("inv");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oem_write_scheduler.md
Name: oem_write_scheduler

Overview:
- Sits between the STI serializer output (so_data/so_valid) and the eight DAC pixel memories (odd1..odd4, even1..even4; 32 x 8 bits each).
- Packs the serial bit stream into bytes and assigns each byte a pixel index 0..255.
- Schedules one write strobe per byte into the correct bank and address using a checkerboard mapping.
- After the stream ends, pads the remaining pixels with a fill value, then asserts oem_finish.

Parameters:
- PAD_VALUE, 8'h00, byte written to every pixel not supplied by the stream.
- CHECKER_INV, 0, 1 inverts the odd/even bank selection.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- so_data  in  1  serial data bit, MSB of each byte first
- so_valid  in  1  so_data is valid this cycle
- pi_end  in  1  level; high means the current/next serial burst is the last
- oem_addr  out  5  bank word address
- oem_dataout  out  8  write data
- odd1_wr, odd2_wr, odd3_wr, odd4_wr  out  1 each  odd bank write strobes
- even1_wr, even2_wr, even3_wr, even4_wr  out  1 each  even bank write strobes
- oem_finish  out  1  all 256 pixels written; sticky
- pix_cnt  out  9  number of pixels written so far (0..256)

Behaviour:
- Reset: all outputs 0, bit counter 0, pixel index 0, end flag cleared, FSM in COLLECT.
- Packer:
  - Each cycle with so_valid=1, shift so_data into an 8-bit shift register (first bit ends up in bit 7).
  - On the 8th bit, copy the byte to a hold register, raise a pending flag, and clear the bit counter.
  - The packer keeps accepting bits while a write is in progress. This is legal because a byte takes at least 8 cycles and a write takes 2.
- End detect:
  - End is armed on a so_valid 1->0 transition while pi_end=1. Only a falling edge arms it; pi_end high with so_valid low and no preceding burst does not.
  - If the bit counter is nonzero at arm time, the partial byte is zero-filled in its LSBs and made pending.
- Address mapping for pixel index p[7:0]:
  - bank = p[7:6] (0 -> bank 1 ... 3 -> bank 4)
  - addr = p[5:1]
  - parity = p[4] ^ p[0] ^ CHECKER_INV; parity 0 selects the odd bank, 1 the even bank.
- Write protocol (2 cycles per write):
  - Cycle N (SETUP): oem_addr and oem_dataout are driven, all strobes 0.
  - Cycle N+1 (STROBE): exactly one strobe is 1; addr and data are unchanged.
  - Cycle N+2: strobe returns to 0, pix_cnt increments, p increments.
  - addr and data hold their values until the next SETUP.
- FSM states: COLLECT, SETUP, STROBE, PAD_SETUP, PAD_STROBE, DONE.
  - COLLECT -> SETUP when pending=1 (pending clears on entry to SETUP).
  - SETUP -> STROBE unconditionally.
  - STROBE -> COLLECT.
  - COLLECT -> PAD_SETUP when end is armed, pending=0, and p<256.
  - PAD_SETUP/PAD_STROBE loop writes PAD_VALUE until the 256th write.
  - Any state -> DONE after the 256th strobe cycle. oem_finish=1 in the cycle after that strobe and stays high until reset.
- Boundary conditions:
  - More than 256 bytes: extra bits and bytes are dropped; no strobe is issued once pix_cnt=256.
  - The 256th byte arriving from the stream goes straight to DONE with no padding.
  - A byte completing in the same cycle end arms is written first, then padding starts.
  - Reset asserted mid-write forces all strobes low in the next cycle; partial data is discarded.
  - pi_end toggling after end is armed is ignored.
- Never more than one strobe high at a time. Strobes are never high in two consecutive cycles.

Test Plan:
- Stream bits 1,0,1,0,0,1,0,1 then pi_end=1 and so_valid falls -> byte 8'hA5 written with odd1_wr at addr 0; PAD_VALUE written to pixels 1..255; oem_finish=1 after the 256th strobe; pix_cnt=256.
- Stream 256 bytes with value = pixel index -> pixel 17 (p[4]=1, p[0]=1, parity 0) goes to odd1 addr 8 with data 8'h11; pixel 16 goes to even1 addr 8; pixel 200 goes to odd4 addr 4; no pad writes occur.
- 3 bits 1,1,1 then end armed -> 8'hE0 written at pixel 0, then 255 pad writes.
- 260 bytes streamed -> exactly 256 strobes; the last 4 bytes never appear on any bus.
- Assert reset one cycle after a SETUP cycle -> no strobe follows; outputs and pix_cnt return to 0; a fresh stream then writes from pixel 0.
- CHECKER_INV=1 with a single byte 8'h3C at pixel 0 -> written via even1_wr at addr 0 instead of odd1_wr.
